// File: rtl/ysyx_25040105_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM state encoding, the default boot address and the instruction width.
package ysyx_25040105_fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ysyx_25040105_fetch_wdt.sv
// Watchdog for the fetch WAIT state: counts response-less cycles and flags expiry
// during the TIMEOUT-th consecutive waiting cycle.
module ysyx_25040105_fetch_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of waiting cycles already elapsed, so the current
    // cycle is the TIMEOUT-th one when cnt == TIMEOUT-1.
    assign expired = enable && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_25040105_fetch_ctrl.sv
// Instruction fetch controller: issues one read at a time, holds the returned word
// until the core commits it, follows redirects and latches a terminal fault.
module ysyx_25040105_fetch_ctrl
    import ysyx_25040105_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    // Memory side. A request transfers on a cycle with req_valid & req_ready;
    // req_valid drops only after that handshake, and one response (resp_valid)
    // is expected from the cycle after the handshake onward.
    output logic              req_valid,
    output logic [31:0]       req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic              resp_err,
    input  logic [INST_W-1:0] resp_data,
    // Core side. inst/pc are held stable while inst_valid is high until inst_ready.
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc,
    input  logic              inst_ready,
    input  logic              jump_en,
    input  logic [31:0]       jump_addr,
    output logic              fetch_fault,
    output logic [31:0]       fault_pc,
    output logic [31:0]       inst_cnt,
    output fetch_state_e      dbg_state
);

    fetch_state_e state;
    logic         wdt_clear;
    logic         wdt_enable;
    logic         wdt_expired;

    assign wdt_clear  = (state != S_WAIT);
    assign wdt_enable = (state == S_WAIT) && !resp_valid;

    ysyx_25040105_fetch_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clear  (wdt_clear),
        .enable (wdt_enable),
        .expired(wdt_expired)
    );

    assign req_addr  = pc;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inst        <= '0;
            inst_cnt    <= '0;
            fault_pc    <= '0;
            fetch_fault <= 1'b0;
            req_valid   <= 1'b1;
            inst_valid  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_ready) begin
                        state     <= S_WAIT;
                        req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (resp_valid && resp_err) begin
                        state       <= S_FAULT;
                        fault_pc    <= pc;
                        fetch_fault <= 1'b1;
                    end else if (resp_valid) begin
                        state      <= S_HOLD;
                        inst       <= resp_data;
                        inst_valid <= 1'b1;
                    end else if (wdt_expired) begin
                        state       <= S_FAULT;
                        fault_pc    <= pc;
                        fetch_fault <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_cnt   <= inst_cnt + 32'd1;
                        inst_valid <= 1'b0;
                        // A misaligned redirect still retires the current instruction.
                        if (jump_en && (jump_addr[1:0] != 2'b00)) begin
                            state       <= S_FAULT;
                            fault_pc    <= jump_addr;
                            fetch_fault <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            req_valid <= 1'b1;
                            pc        <= jump_en ? jump_addr : pc + 32'd4;
                        end
                    end
                end
                default: begin
                    state       <= S_FAULT;
                    req_valid   <= 1'b0;
                    inst_valid  <= 1'b0;
                    fetch_fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_fetch_ctrl.sv
// Directed bench for the fetch controller: hand-computed addresses, counts and
// fault reports for boot, redirect, stalls, errors, timeout, misalignment and wrap.
module tb_ysyx_25040105_fetch_ctrl;
    import ysyx_25040105_fetch_pkg::*;

    localparam int TIMEOUT = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_err;
    logic [INST_W-1:0] resp_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic              inst_ready;
    logic              jump_en;
    logic [31:0]       jump_addr;
    logic              fetch_fault;
    logic [31:0]       fault_pc;
    logic [31:0]       inst_cnt;
    fetch_state_e      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_25040105_fetch_ctrl #(
        .RESET_PC(32'h8000_0000),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .inst_ready (inst_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .fetch_fault(fetch_fault),
        .fault_pc   (fault_pc),
        .inst_cnt   (inst_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        inst_ready = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // One complete fetch with zero stall: REQ, WAIT (response at once), HOLD (commit at once).
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic jen, input logic [31:0] jaddr);
        chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
        chk({tag, "_req_addr"}, req_addr, addr);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk({tag, "_wait_req_valid"}, 32'(req_valid), 32'd0);
        resp_valid = 1'b1;
        resp_data  = data;
        tick();
        resp_valid = 1'b0;
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_inst"}, inst, data);
        chk({tag, "_pc"}, pc, addr);
        inst_ready = 1'b1;
        jump_en    = jen;
        jump_addr  = jaddr;
        tick();
        inst_ready = 1'b0;
        jump_en    = 1'b0;
    endtask

    initial begin
        // reset values while rst is held low
        do_reset();
        chk("rst_state", 32'(dbg_state), 32'(S_REQ));
        chk("rst_inst_cnt", inst_cnt, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);

        // boot fetch, then sequential next address
        fetch_one("boot", 32'h8000_0000, 32'h0010_0093, 1'b0, 32'd0);
        chk("boot_next_addr", req_addr, 32'h8000_0004);
        chk("boot_inst_cnt", inst_cnt, 32'd1);

        // aligned redirect
        fetch_one("jmp", 32'h8000_0004, 32'h1234_5678, 1'b1, 32'h8000_0100);
        chk("jmp_next_addr", req_addr, 32'h8000_0100);
        chk("jmp_inst_cnt", inst_cnt, 32'd2);

        // memory stall in REQ with a stray response that must be ignored
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req_valid", 32'(req_valid), 32'd1);
            chk("stall_req_addr", req_addr, 32'h8000_0100);
        end
        resp_valid = 1'b0;
        req_ready  = 1'b1;
        tick();
        req_ready  = 1'b0;
        chk("stall_in_wait", 32'(dbg_state), 32'(S_WAIT));
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0013;
        tick();
        resp_valid = 1'b0;
        // core stall in HOLD; redirect must be ignored without inst_ready
        jump_en   = 1'b1;
        jump_addr = 32'h9000_0000;
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_inst_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, 32'h0000_0013);
            chk("hold_pc", pc, 32'h8000_0100);
            chk("hold_no_req", 32'(req_valid), 32'd0);
            tick();
        end
        jump_en    = 1'b0;
        req_ready  = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("hold_inst_cnt", inst_cnt, 32'd3);
        chk("hold_next_addr", req_addr, 32'h8000_0104);

        // slow response: three empty WAIT cycles, then redirect to 8000_0008
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("slow_wait_state", 32'(dbg_state), 32'(S_WAIT));
            chk("slow_wait_valid", 32'(inst_valid), 32'd0);
        end
        resp_valid = 1'b1;
        resp_data  = 32'hCAFE_0001;
        tick();
        resp_valid = 1'b0;
        chk("slow_inst", inst, 32'hCAFE_0001);
        inst_ready = 1'b1;
        jump_en    = 1'b1;
        jump_addr  = 32'h8000_0008;
        tick();
        inst_ready = 1'b0;
        jump_en    = 1'b0;
        chk("slow_next_addr", req_addr, 32'h8000_0008);
        chk("slow_inst_cnt", inst_cnt, 32'd4);

        // error response -> terminal fault
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        chk("err_fault", 32'(fetch_fault), 32'd1);
        chk("err_fault_pc", fault_pc, 32'h8000_0008);
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            resp_valid = (i % 2 == 0);
            tick();
            chk("err_no_req", 32'(req_valid), 32'd0);
            chk("err_no_inst", 32'(inst_valid), 32'd0);
        end
        chk("err_sticky", 32'(fetch_fault), 32'd1);
        chk("err_inst_cnt", inst_cnt, 32'd4);
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("err_rst_req_valid", 32'(req_valid), 32'd1);
        chk("err_rst_req_addr", req_addr, 32'h8000_0000);
        chk("err_rst_fault", 32'(fetch_fault), 32'd0);
        chk("err_rst_inst_cnt", inst_cnt, 32'd0);

        // timeout: exactly TIMEOUT empty WAIT cycles
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_before", 32'(fetch_fault), 32'd0);
        chk("to_before_state", 32'(dbg_state), 32'(S_WAIT));
        tick();
        chk("to_fault", 32'(fetch_fault), 32'd1);
        chk("to_fault_pc", fault_pc, 32'h8000_0000);
        resp_valid = 1'b1;
        resp_data  = 32'h1111_1111;
        tick();
        resp_valid = 1'b0;
        chk("to_late_resp", 32'(inst_valid), 32'd0);

        // reset mid-transaction; a late response afterwards is ignored
        do_reset();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 32'h2222_2222;
        tick();
        resp_valid = 1'b0;
        chk("mid_rst_req_valid", 32'(req_valid), 32'd1);
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_req_addr", req_addr, 32'h8000_0000);

        // misaligned redirect: counted commit, then fault
        fetch_one("mis", 32'h8000_0000, 32'h0000_0013, 1'b1, 32'h8000_0102);
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h8000_0102);
        chk("mis_inst_cnt", inst_cnt, 32'd1);
        chk("mis_req_valid", 32'(req_valid), 32'd0);

        // address wrap at the top of the space
        do_reset();
        fetch_one("wrap0", 32'h8000_0000, 32'h0000_0013, 1'b1, 32'hFFFF_FFFC);
        fetch_one("wrap1", 32'hFFFF_FFFC, 32'h0000_0073, 1'b0, 32'd0);
        chk("wrap_next_addr", req_addr, 32'h0000_0000);
        chk("wrap_inst_cnt", inst_cnt, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25040105_fetch_ctrl.md
YSYX_25040105_FETCH_CTRL -- requirements
Module: ysyx_25040105_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of WAIT cycles before a fetch fault.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 req_valid  output  1  SHALL signal a memory read request.
REQ-006 req_addr  output  32  SHALL carry the request address.
REQ-007 req_ready  input  1  SHALL signal that memory accepts the request.
REQ-008 resp_valid, resp_err  input  1 each  SHALL signal a response and its error flag.
REQ-009 resp_data  input  32  SHALL carry the fetched instruction word.
REQ-010 inst_valid  output  1  SHALL signal that inst and pc hold a fetched instruction.
REQ-011 inst, pc  output  32 each  SHALL be the instruction word and its address, for IDU/EXU.
REQ-012 inst_ready  input  1  SHALL signal that the core commits the presented instruction this cycle.
REQ-013 jump_en, jump_addr  input  1, 32  SHALL be the redirect, sampled only on an inst_valid & inst_ready cycle.
REQ-014 fetch_fault  output  1  SHALL be a sticky fault flag; fault_pc  output  32  SHALL be the faulting address.
REQ-015 inst_cnt  output  32  SHALL count committed instructions.

Function
REQ-016 FSM SHALL have exactly four states: REQ, WAIT, HOLD, FAULT.
REQ-017 REQ: req_valid=1, req_addr=pc; on req_ready -> WAIT, WAIT counter cleared.
REQ-018 WAIT: req_valid=0; resp_valid&!resp_err -> latch resp_data into inst, -> HOLD; resp_valid&resp_err -> FAULT with fault_pc=pc.
REQ-019 resp_valid SHALL be ignored in REQ, HOLD and FAULT; earliest usable response is the cycle after the req handshake.
REQ-020 WAIT counter SHALL increment each WAIT cycle without a response; on reaching TIMEOUT -> FAULT with fault_pc=pc.
REQ-021 HOLD: inst_valid=1, inst/pc stable; on inst_ready -> REQ, pc <= jump_en ? jump_addr : pc+4 (mod 2^32), inst_cnt += 1 (wraps).
REQ-022 On commit with jump_en=1 and jump_addr[1:0]!=0 -> FAULT, fault_pc=jump_addr, inst_cnt still increments.
REQ-023 FAULT SHALL be terminal until reset: req_valid=0, inst_valid=0, fetch_fault=1.
REQ-024 inst_valid SHALL be 1 only in HOLD; req_valid only in REQ.
REQ-025 Minimum throughput SHALL be one committed instruction per 3 cycles (REQ, WAIT, HOLD).
REQ-026 Outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-027 While rst=0 at a clock edge: state=REQ, pc=RESET_PC, inst=0, inst_cnt=0, fault_pc=0, fetch_fault=0, WAIT counter=0.
REQ-028 req_valid SHALL be 1 in the first cycle after rst rises, with req_addr=RESET_PC.
REQ-029 Reset asserted mid-transaction SHALL abandon it; a late response after reset is ignored per REQ-019.

Structure
REQ-030 Package ysyx_25040105_fetch_pkg SHALL hold the state enum, default RESET_PC, and the instruction width constant.
REQ-031 The WAIT timeout counter SHALL be a sub-module ysyx_25040105_fetch_wdt (clear, enable, expired).

Verification
REQ-032 Reset release, req_ready=1, response 1 cycle later with 32'h00100093, inst_ready=1 -> req_addr=8000_0000, inst_valid in cycle 3, next req_addr=8000_0004, inst_cnt=1.
REQ-033 Commit with jump_en=1, jump_addr=8000_0100 -> next req_addr=8000_0100.
REQ-034 req_ready low 5 cycles, inst_ready low 4 cycles in HOLD -> req_addr and inst/pc held stable, no duplicate requests, inst_cnt increments once.
REQ-035 resp_err=1 at pc 8000_0008 -> fetch_fault=1, fault_pc=8000_0008, req_valid stays 0 for 20 cycles; rst pulse -> req_addr=8000_0000.
REQ-036 No response for TIMEOUT cycles -> FAULT; jump_addr=8000_0102 on commit -> FAULT, fault_pc=8000_0102.
REQ-037 pc=FFFF_FFFC commit, no jump -> next req_addr=0000_0000.
